// File: rtl/cntr_pkg.sv
// Shared constants, pairing FSM encoding and word packing for the counter pair packer.
package cntr_pkg;

  localparam int unsigned CNTR_W = 10;
  localparam int unsigned SEQ_W  = 6;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned PAD_W  = WORD_W - SEQ_W - 2 * CNTR_W;

  typedef enum logic {
    IDLE,
    HAVE_FIRST
  } pair_state_e;

  // Word layout: {seq, first sample, zero pad, second sample}
  function automatic logic [WORD_W-1:0] pack_word(
    input logic [SEQ_W-1:0]  seq,
    input logic [CNTR_W-1:0] first,
    input logic [CNTR_W-1:0] second
  );
    return {seq, first, {PAD_W{1'b0}}, second};
  endfunction

endpackage

// File: rtl/cntr_pair_packer_if.sv
// Sample input stream and show-ahead readout port of the counter pair packer.
interface cntr_pair_packer_if;
  import cntr_pkg::*;

  logic [CNTR_W-1:0] cntr;
  logic              cntr_valid;
  logic [WORD_W-1:0] data_out;
  logic              data_out_valid;
  logic              data_out_read;

  // Producer of samples and consumer of words
  modport master (
    output cntr, cntr_valid, data_out_read,
    input  data_out, data_out_valid
  );

  // The packer itself
  modport slave (
    input  cntr, cntr_valid, data_out_read,
    output data_out, data_out_valid
  );

endinterface

// File: rtl/cntr_pair_packer_word_fifo.sv
// Synchronous show-ahead word FIFO; head is presented combinationally, zero when empty.
module word_fifo
  import cntr_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             rd_accept;
  logic             wr_accept;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_CNT);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Accept pops only when data exists; a write into a full FIFO is allowed only
  // when the head is leaving on the same edge (the slot being written is the head).
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_accept = rd_en && !empty;
    wr_accept = wr_en && (!full || rd_accept);
    if (wr_accept) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cntr_pair_packer.sv
// Pairs consecutive counter samples into sequence-numbered words and buffers them for readout.
module cntr_pair_packer
  import cntr_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  cntr_pair_packer_if.slave  bus
);

  pair_state_e       state_q, state_d;
  logic [CNTR_W-1:0] first_q, first_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              push;
  logic              fifo_wr;
  logic [WORD_W-1:0] push_word;
  logic              fifo_empty;
  logic              fifo_full;

  // State, held first sample and sequence number
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      first_q <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      seq_q   <= seq_d;
    end
  end

  // Each strobe toggles between waiting for the first and the second sample
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (bus.cntr_valid) state_d = HAVE_FIRST;
      HAVE_FIRST: if (bus.cntr_valid) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Capture the first sample; on the second, emit the word and advance seq even if it is dropped
  always_comb begin
    first_d   = first_q;
    seq_d     = seq_q;
    push      = 1'b0;
    push_word = pack_word(seq_q, first_q, bus.cntr);
    case (state_q)
      IDLE: begin
        if (bus.cntr_valid) first_d = bus.cntr;
      end
      HAVE_FIRST: begin
        if (bus.cntr_valid) begin
          push  = 1'b1;
          seq_d = seq_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Drop on full unless a pop frees the head slot on the same edge
  assign fifo_wr = push && (!fifo_full || (bus.data_out_read && !fifo_empty));

  word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .wr_en   (fifo_wr),
    .wr_data (push_word),
    .rd_en   (bus.data_out_read),
    .rd_data (bus.data_out),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign bus.data_out_valid = !fifo_empty;

endmodule

// File: tb/tb_cntr_pair_packer.sv
// Directed scoreboard bench for cntr_pair_packer.
module tb_cntr_pair_packer;
  import cntr_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cntr_pair_packer_if bus ();

  cntr_pair_packer #(.FIFO_DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] sb[$];
  logic        pend;
  logic [9:0]  m_first;
  logic [5:0]  m_seq;
  logic [31:0] last_pop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.cntr_valid    = 1'b0;
    bus.cntr          = '0;
    bus.data_out_read = 1'b0;
    #3;
    check("rst_data", bus.data_out, 32'h0);
    check("rst_valid", {31'b0, bus.data_out_valid}, 32'h0);
    sb.delete();
    pend  = 1'b0;
    m_seq = '0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // One clock: drive inputs, update model at the edge, check outputs after it
  task automatic cycle(input logic v, input logic [9:0] val, input logic rd);
    logic        pop;
    logic        done;
    int unsigned n_before;
    logic [31:0] w;
    bus.cntr_valid    = v;
    bus.cntr          = val;
    bus.data_out_read = rd;
    n_before = sb.size();
    pop  = rd && (n_before != 0);
    done = v && pend;
    w    = {m_seq, m_first, 6'b000000, val};
    if (pop) check("pop_head", bus.data_out, sb[0]);
    @(posedge clk); #1;
    if (pop) last_pop = sb.pop_front();
    if (done) begin
      if (n_before < 16 || pop) sb.push_back(w);
      m_seq++;
      pend = 1'b0;
    end else if (v) begin
      m_first = val;
      pend    = 1'b1;
    end
    bus.cntr_valid    = 1'b0;
    bus.data_out_read = 1'b0;
    check("valid", {31'b0, bus.data_out_valid}, {31'b0, sb.size() != 0});
    check("head", bus.data_out, (sb.size() != 0) ? sb[0] : 32'h0);
  endtask

  task automatic pair(input logic [9:0] a, input logic [9:0] b);
    cycle(1'b1, a, 1'b0);
    cycle(1'b1, b, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lit2 [4];
    logic [31:0] e;
    logic [31:0] last;
    logic [5:0]  s;
    int          n;

    rst = 1'b1;

    // 1: first word latency and layout
    do_reset();
    cycle(1'b1, 10'd800, 1'b0);
    cycle(1'b1, 10'd200, 1'b0);
    check("t1_word", bus.data_out, 32'h032000C8);
    check("t1_valid", {31'b0, bus.data_out_valid}, 32'h1);

    // 2: four pairs, drain in order
    do_reset();
    repeat (4) pair(10'd800, 10'd200);
    lit2[0] = 32'h032000C8;
    lit2[1] = 32'h072000C8;
    lit2[2] = 32'h0B2000C8;
    lit2[3] = 32'h0F2000C8;
    for (int i = 0; i < 4; i++) begin
      check("t2_word", bus.data_out, lit2[i]);
      cycle(1'b0, 10'd0, 1'b1);
    end
    check("t2_empty_data", bus.data_out, 32'h0);
    check("t2_empty_valid", {31'b0, bus.data_out_valid}, 32'h0);

    // 3: reset mid-pair discards the held sample
    do_reset();
    cycle(1'b1, 10'd800, 1'b0);
    do_reset();
    pair(10'd200, 10'd800);
    check("t3_word", bus.data_out, 32'h00C80320);
    cycle(1'b0, 10'd0, 1'b1);
    check("t3_empty", {31'b0, bus.data_out_valid}, 32'h0);

    // 4: overflow drops the 17th pair, seq gap visible
    do_reset();
    repeat (17) pair(10'd200, 10'd800);
    check("t4_head", bus.data_out, 32'h00C80320);
    cycle(1'b0, 10'd0, 1'b1);
    pair(10'd200, 10'd800);
    for (int i = 1; i < 16; i++) begin
      s = 6'(i);
      e = {s, 26'h0C80320};
      check("t4_word", bus.data_out, e);
      cycle(1'b0, 10'd0, 1'b1);
    end
    check("t4_seq17", bus.data_out, 32'h44C80320);
    cycle(1'b0, 10'd0, 1'b1);
    check("t4_empty", {31'b0, bus.data_out_valid}, 32'h0);

    // 5: full FIFO, push and pop on the same edge
    do_reset();
    repeat (16) pair(10'd200, 10'd800);
    cycle(1'b1, 10'd200, 1'b0);
    cycle(1'b1, 10'd800, 1'b1);
    n    = 0;
    last = '0;
    while (bus.data_out_valid && n < 40) begin
      last = bus.data_out;
      cycle(1'b0, 10'd0, 1'b1);
      n++;
    end
    check("t5_count", 32'(n), 32'd16);
    check("t5_last", last, 32'h40C80320);

    // 6: reads while empty, read on the first push edge
    do_reset();
    repeat (3) cycle(1'b0, 10'd0, 1'b1);
    check("t6_empty", {31'b0, bus.data_out_valid}, 32'h0);
    cycle(1'b1, 10'd200, 1'b0);
    cycle(1'b1, 10'd800, 1'b1);
    check("t6_word", bus.data_out, 32'h00C80320);
    check("t6_valid", {31'b0, bus.data_out_valid}, 32'h1);
    cycle(1'b0, 10'd0, 1'b0);
    check("t6_hold", bus.data_out, 32'h00C80320);
    cycle(1'b0, 10'd0, 1'b1);
    check("t6_drained", {31'b0, bus.data_out_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
